// File: rtl/weighted_vote_controller_if.sv
// Voter/config/decision bus for weighted_vote_controller.
// Carries dup_err only when VOTE_DUP_ERR_EN is defined.
interface weighted_vote_controller_if #(
    parameter int unsigned N_VOTERS = 6
);
    logic                cfg_we;
    logic [N_VOTERS-1:0] cfg_doubles;
    logic                start;
    logic                vote_valid;
    logic [2:0]          vote_id;
    logic                vote_value;
    logic                vote_ready;
    logic                busy;
    logic [N_VOTERS-1:0] voted_mask;
    logic [3:0]          tally;
    logic                result;
    logic                result_valid;
    logic                timed_out;
`ifdef VOTE_DUP_ERR_EN
    logic                dup_err;
`endif

    modport master (
        output cfg_we,
        output cfg_doubles,
        output start,
        output vote_valid,
        output vote_id,
        output vote_value,
        input  vote_ready,
        input  busy,
        input  voted_mask,
        input  tally,
        input  result,
        input  result_valid,
`ifdef VOTE_DUP_ERR_EN
        input  dup_err,
`endif
        input  timed_out
    );

    modport slave (
        input  cfg_we,
        input  cfg_doubles,
        input  start,
        input  vote_valid,
        input  vote_id,
        input  vote_value,
        output vote_ready,
        output busy,
        output voted_mask,
        output tally,
        output result,
        output result_valid,
`ifdef VOTE_DUP_ERR_EN
        output dup_err,
`endif
        output timed_out
    );
endinterface

// File: rtl/weighted_vote_controller.sv
// Serial six-voter weighted majority sequencer: collects one vote per voter, tallies, publishes.
// Optional macro VOTE_DUP_ERR_EN adds a sticky dup_err flag for duplicate/out-of-range votes.
module weighted_vote_controller #(
    parameter int unsigned N_VOTERS       = 6,
    parameter int unsigned THRESHOLD      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                        i_clk,
    input logic                        i_reset,
    weighted_vote_controller_if.slave  bus
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] Thresh = 4'(THRESHOLD);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StTally,
        StDone
    } state_e;

    state_e              r_state, w_state_d;
    logic [N_VOTERS-1:0] r_weights, w_weights_d;
    logic [N_VOTERS-1:0] r_mask, w_mask_d;
    logic [3:0]          r_tally, w_tally_d;
    logic [TimerW-1:0]   r_timer, w_timer_d;
    logic                r_result, w_result_d;
    logic                r_timed_out, w_timed_out_d;
`ifdef VOTE_DUP_ERR_EN
    logic                r_dup_err, w_dup_err_d;
`endif

    logic [N_VOTERS-1:0] w_id_oh;
    logic                w_in_range;
    logic                w_is_new;
    logic [3:0]          w_inc;
    logic [N_VOTERS-1:0] w_mask_next;

    // One-hot of vote_id; out-of-range ids shift off the top and give zero.
    assign w_id_oh    = N_VOTERS'(1) << bus.vote_id;
    assign w_in_range = (32'(bus.vote_id) < N_VOTERS);
    assign w_is_new   = bus.vote_valid && w_in_range && ((r_mask & w_id_oh) == '0);
    assign w_inc      = !bus.vote_value ? 4'd0 :
                        ((r_weights & w_id_oh) != '0) ? 4'd2 : 4'd1;
    assign w_mask_next = w_is_new ? (r_mask | w_id_oh) : r_mask;

    always_comb begin
        w_state_d     = r_state;
        w_weights_d   = r_weights;
        w_mask_d      = r_mask;
        w_tally_d     = r_tally;
        w_timer_d     = r_timer;
        w_result_d    = r_result;
        w_timed_out_d = r_timed_out;
`ifdef VOTE_DUP_ERR_EN
        w_dup_err_d   = r_dup_err;
`endif
        unique case (r_state)
            StIdle: begin
                if (bus.cfg_we) begin
                    w_weights_d = bus.cfg_doubles;
                end
                if (bus.start) begin
                    w_state_d     = StCollect;
                    w_mask_d      = '0;
                    w_tally_d     = '0;
                    w_timer_d     = '0;
                    w_timed_out_d = 1'b0;
`ifdef VOTE_DUP_ERR_EN
                    w_dup_err_d   = 1'b0;
`endif
                end
            end
            StCollect: begin
                w_timer_d = r_timer + TimerW'(1);
                if (w_is_new) begin
                    w_mask_d  = w_mask_next;
                    w_tally_d = r_tally + w_inc;
                end
`ifdef VOTE_DUP_ERR_EN
                if (bus.vote_valid && !w_is_new) begin
                    w_dup_err_d = 1'b1;
                end
`endif
                // A completing vote on the timeout cycle wins over the timeout.
                if (&w_mask_next) begin
                    w_state_d = StTally;
                end else if (r_timer == TimerLast) begin
                    w_state_d     = StTally;
                    w_timed_out_d = 1'b1;
                end
            end
            StTally: begin
                w_result_d = (r_tally >= Thresh);
                w_state_d  = StDone;
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_weights   <= '0;
            r_mask      <= '0;
            r_tally     <= '0;
            r_timer     <= '0;
            r_result    <= 1'b0;
            r_timed_out <= 1'b0;
`ifdef VOTE_DUP_ERR_EN
            r_dup_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_weights   <= w_weights_d;
            r_mask      <= w_mask_d;
            r_tally     <= w_tally_d;
            r_timer     <= w_timer_d;
            r_result    <= w_result_d;
            r_timed_out <= w_timed_out_d;
`ifdef VOTE_DUP_ERR_EN
            r_dup_err   <= w_dup_err_d;
`endif
        end
    end

    assign bus.vote_ready   = (r_state == StCollect);
    assign bus.busy         = (r_state != StIdle);
    assign bus.result_valid = (r_state == StDone);
    assign bus.voted_mask   = r_mask;
    assign bus.tally        = r_tally;
    assign bus.result       = r_result;
    assign bus.timed_out    = r_timed_out;
`ifdef VOTE_DUP_ERR_EN
    assign bus.dup_err      = r_dup_err;
`endif

endmodule

// File: tb/tb_weighted_vote_controller.sv
// Bench for weighted_vote_controller: vector table, corner sequences, and random sessions
// checked against a per-session vote-counting model.
module tb_weighted_vote_controller;

    logic clk = 1'b0;
    logic reset;

    weighted_vote_controller_if vif ();

    weighted_vote_controller dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] id;
        logic       val;
    } op_t;

    typedef struct {
        logic [5:0] dbl;
        logic [5:0] present;
        logic [5:0] yes;
        logic [3:0] e_tally;
        logic       e_res;
        logic       e_to;
        int         e_cyc;
    } vec_t;

    int errors = 0;
    int checks = 0;
    op_t op_q[$];
    logic [5:0] cur_w = '0;
    logic last_result = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_op(input logic v, input int id, input logic val);
        op_t o;
        o.v = v;
        o.id = 3'(id);
        o.val = val;
        op_q.push_back(o);
    endtask

    // Reference: first valid vote per voter counts, session closes on full roll or 16th cycle.
    task automatic model(input logic [5:0] w, output logic [3:0] t, output logic r,
                         output logic to, output int cyc, output logic dup);
        int sum;
        int nv;
        bit voted[6];
        bit done;
        sum = 0;
        dup = 1'b0;
        done = 0;
        cyc = 16;
        for (int i = 0; i < 6; i++) voted[i] = 0;
        for (int c = 0; c < 16 && !done; c++) begin
            if (c < op_q.size() && op_q[c].v) begin
                if (op_q[c].id < 6 && !voted[op_q[c].id]) begin
                    voted[op_q[c].id] = 1;
                    if (op_q[c].val) sum += w[op_q[c].id] ? 2 : 1;
                end else begin
                    dup = 1'b1;
                end
            end
            nv = 0;
            for (int i = 0; i < 6; i++) nv += voted[i] ? 1 : 0;
            if (nv == 6) begin
                cyc = c + 1;
                done = 1;
            end
        end
        to = !done;
        t = 4'(sum);
        r = (sum >= 3);
    endtask

    task automatic run_session(input logic [5:0] dbl, input bit with_cfg, input logic [3:0] e_tally,
                               input logic e_res, input logic e_to, input int e_cyc,
                               input logic e_dup);
        int cyc;
        int k;
        vif.cfg_we = with_cfg;
        vif.cfg_doubles = dbl;
        vif.start = 1'b1;
        tick();
        vif.cfg_we = 1'b0;
        vif.start = 1'b0;
        if (with_cfg) cur_w = dbl;
        check("start_busy", vif.busy, 1'b1);
        check("start_mask", vif.voted_mask, 6'd0);
        check("start_tally", vif.tally, 4'd0);
        check("start_timed_out", vif.timed_out, 1'b0);
        check("start_result_hold", vif.result, last_result);
        cyc = 0;
        k = 0;
        while (vif.vote_ready === 1'b1 && cyc < 40) begin
            cyc++;
            if (k < op_q.size()) begin
                vif.vote_valid = op_q[k].v;
                vif.vote_id = op_q[k].id;
                vif.vote_value = op_q[k].val;
            end else begin
                vif.vote_valid = 1'b0;
            end
            k++;
            tick();
        end
        vif.vote_valid = 1'b0;
        check("collect_cycles", cyc, e_cyc);
        check("tally_state_rv", vif.result_valid, 1'b0);
        check("tally_value", vif.tally, e_tally);
        tick();
        check("done_rv", vif.result_valid, 1'b1);
        check("done_result", vif.result, e_res);
        check("done_timed_out", vif.timed_out, e_to);
`ifdef VOTE_DUP_ERR_EN
        check("done_dup_err", vif.dup_err, e_dup);
`endif
        tick();
        check("idle_rv", vif.result_valid, 1'b0);
        check("idle_busy", vif.busy, 1'b0);
        check("idle_result_hold", vif.result, e_res);
        last_result = e_res;
    endtask

    vec_t vecs[8];

    initial begin
        logic [3:0] m_t;
        logic m_r;
        logic m_to;
        logic m_dup;
        int m_cyc;
        logic [5:0] d;
        int mode;

        vecs[0] = '{6'b000000, 6'b111111, 6'b000111, 4'd3, 1'b1, 1'b0, 6};
        vecs[1] = '{6'b000011, 6'b111111, 6'b000001, 4'd2, 1'b0, 1'b0, 6};
        vecs[2] = '{6'b000011, 6'b111111, 6'b000011, 4'd4, 1'b1, 1'b0, 6};
        vecs[3] = '{6'b111111, 6'b000011, 6'b000011, 4'd4, 1'b1, 1'b1, 16};
        vecs[4] = '{6'b000000, 6'b000000, 6'b000000, 4'd0, 1'b0, 1'b1, 16};
        vecs[5] = '{6'b101010, 6'b111111, 6'b111111, 4'd9, 1'b1, 1'b0, 6};
        vecs[6] = '{6'b000000, 6'b111111, 6'b000011, 4'd2, 1'b0, 1'b0, 6};
        vecs[7] = '{6'b111111, 6'b111111, 6'b111111, 4'd12, 1'b1, 1'b0, 6};

        reset = 1'b1;
        vif.cfg_we = 1'b0;
        vif.cfg_doubles = '0;
        vif.start = 1'b0;
        vif.vote_valid = 1'b0;
        vif.vote_id = '0;
        vif.vote_value = 1'b0;
        tick();
        tick();
        check("rst_busy", vif.busy, 1'b0);
        check("rst_ready", vif.vote_ready, 1'b0);
        check("rst_mask", vif.voted_mask, 6'd0);
        check("rst_tally", vif.tally, 4'd0);
        check("rst_result", vif.result, 1'b0);
        check("rst_rv", vif.result_valid, 1'b0);
        check("rst_timed_out", vif.timed_out, 1'b0);
`ifdef VOTE_DUP_ERR_EN
        check("rst_dup_err", vif.dup_err, 1'b0);
`endif
        reset = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            op_q.delete();
            for (int i = 0; i < 6; i++)
                if (vecs[v].present[i]) push_op(1'b1, i, vecs[v].yes[i]);
            run_session(vecs[v].dbl, 1'b1, vecs[v].e_tally, vecs[v].e_res, vecs[v].e_to,
                        vecs[v].e_cyc, 1'b0);
        end

        // Duplicate vote for id2: first (yes) wins.
        op_q.delete();
        push_op(1'b1, 2, 1'b1);
        push_op(1'b1, 2, 1'b0);
        for (int i = 0; i < 6; i++) if (i != 2) push_op(1'b1, i, 1'b0);
        run_session(6'b000000, 1'b1, 4'd1, 1'b0, 1'b0, 7, 1'b1);

        // Out-of-range ids are dropped while collection continues.
        op_q.delete();
        push_op(1'b1, 6, 1'b1);
        push_op(1'b1, 7, 1'b1);
        for (int i = 0; i < 6; i++) push_op(1'b1, i, 1'b1);
        run_session(6'b000000, 1'b1, 4'd6, 1'b1, 1'b0, 8, 1'b1);

        // Final vote on the timeout cycle counts; one cycle later it does not.
        op_q.delete();
        for (int i = 0; i < 10; i++) push_op(1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) push_op(1'b1, i, 1'b1);
        run_session(6'b000000, 1'b1, 4'd6, 1'b1, 1'b0, 16, 1'b0);
        op_q.delete();
        for (int i = 0; i < 11; i++) push_op(1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) push_op(1'b1, i, 1'b1);
        run_session(6'b000000, 1'b1, 4'd5, 1'b1, 1'b1, 16, 1'b0);

        // Mid-session cfg_we/start are ignored.
        vif.start = 1'b1;
        tick();
        vif.start = 1'b0;
        vif.vote_valid = 1'b1;
        vif.vote_id = 3'd0;
        vif.vote_value = 1'b1;
        tick();
        vif.vote_valid = 1'b0;
        vif.cfg_we = 1'b1;
        vif.cfg_doubles = 6'b111111;
        vif.start = 1'b1;
        tick();
        vif.cfg_we = 1'b0;
        vif.start = 1'b0;
        check("mid_start_ready", vif.vote_ready, 1'b1);
        check("mid_start_mask", vif.voted_mask, 6'b000001);
        check("mid_start_tally", vif.tally, 4'd1);
        for (int i = 1; i < 6; i++) begin
            vif.vote_valid = 1'b1;
            vif.vote_id = 3'(i);
            vif.vote_value = 1'b1;
            tick();
        end
        vif.vote_valid = 1'b0;
        check("mid_cfg_tally", vif.tally, 4'd6);
        tick();
        check("mid_cfg_rv", vif.result_valid, 1'b1);
        check("mid_cfg_result", vif.result, 1'b1);
        tick();

        // Reset mid-session aborts without result_valid.
        vif.start = 1'b1;
        tick();
        vif.start = 1'b0;
        vif.vote_valid = 1'b1;
        vif.vote_id = 3'd0;
        vif.vote_value = 1'b1;
        tick();
        vif.vote_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur_w = '0;
        last_result = 1'b0;
        check("abort_busy", vif.busy, 1'b0);
        check("abort_tally", vif.tally, 4'd0);
        check("abort_result", vif.result, 1'b0);
        check("abort_mask", vif.voted_mask, 6'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_rv", vif.result_valid, 1'b0);
            tick();
        end

        for (int s = 0; s < 40; s++) begin
            d = 6'($urandom);
            mode = $urandom_range(0, 2);
            op_q.delete();
            for (int c = 0; c < 20; c++)
                push_op(($urandom_range(0, 9) < 7), (s % 2 == 0) ? $urandom_range(0, 7) :
                        $urandom_range(0, 5), 1'($urandom));
            if (mode == 2) begin
                vif.cfg_we = 1'b1;
                vif.cfg_doubles = d;
                tick();
                vif.cfg_we = 1'b0;
                cur_w = d;
            end
            model((mode == 1) ? d : cur_w, m_t, m_r, m_to, m_cyc, m_dup);
            run_session(d, (mode == 1), m_t, m_r, m_to, m_cyc, m_dup);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weighted_vote_controller.md
Name: weighted_vote_controller

Overview:
Sequencer for a six-voter weighted majority decision. Opens a voting session on start and collects one vote per voter over a valid/ready interface. Accumulates each voter's weight (1, or 2 when its "double" bit is set) and closes the session when all voters have voted or a timeout expires. Publishes a registered majority result. Sits between the voter sources and downstream consumers of the decision, replacing a purely combinational six-input weighted vote wherever votes arrive serially.

Parameters:
N_VOTERS, 6, number of voters; also the width of cfg_doubles and voted_mask.
THRESHOLD, 3, minimum weighted tally for result = 1.
TIMEOUT_CYCLES, 16, maximum number of COLLECT cycles before the session is forced closed.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
cfg_we  input  1  load cfg_doubles into the weight register.
cfg_doubles  input  6  per-voter double-weight bits; bit i set means weight 2, clear means weight 1.
start  input  1  open a session.
vote_valid  input  1  vote present on vote_id/vote_value.
vote_id  input  3  voter index, 0..N_VOTERS-1.
vote_value  input  1  ballot: 1 = yes, 0 = no.
vote_ready  output  1  high only in COLLECT.
busy  output  1  high in COLLECT, TALLY and DONE.
voted_mask  output  6  voters already counted this session.
tally  output  4  running weighted yes count, 0..12.
result  output  1  registered decision; holds until the next start.
result_valid  output  1  one-cycle pulse when result updates.
timed_out  output  1  set if the last session closed by timeout; holds until the next start.

Behaviour:
- Reset: state = IDLE. All outputs are 0. Weight register = 0 (all voters weight 1). Timer = 0. Reset mid-session aborts the session with no result_valid.
- States are IDLE, COLLECT, TALLY, DONE.
- IDLE:
  - cfg_we loads the weight register. cfg_we in any other state is ignored; weights are frozen during a session.
  - start moves to COLLECT and clears voted_mask, tally, timer and timed_out. result keeps its old value.
  - cfg_we and start in the same cycle: the new weights apply to the session being opened.
- COLLECT:
  - A vote is accepted on vote_valid && vote_ready.
  - vote_id >= N_VOTERS: ignored, no state change.
  - Voter already in voted_mask: ignored; first vote wins.
  - Otherwise: set voted_mask[id]; tally += vote_value ? (weight[id] ? 2 : 1) : 0.
  - The timer increments every COLLECT cycle.
  - Exit to TALLY when voted_mask becomes all-ones, including through the vote accepted this cycle.
  - Exit to TALLY with timed_out = 1 when the timer equals TIMEOUT_CYCLES-1 and the mask is not complete.
  - If the final vote lands on the timeout cycle, the vote is counted and timed_out = 0.
  - Voters absent at timeout contribute 0.
- start while not in IDLE is ignored.
- TALLY (1 cycle): result <= (tally >= THRESHOLD); go to DONE.
- DONE (1 cycle): result_valid = 1; go to IDLE.
- Latency: result_valid is high 2 cycles after the edge that accepts the final vote.
- Arithmetic: tally is 4 bits unsigned; the maximum of 12 cannot overflow. The compare is unsigned.

Optional Feature:
VOTE_DUP_ERR_EN.
- Defined: adds output dup_err (1 bit). It is cleared on start and reset. It is set sticky for the session when a vote_valid arrives in COLLECT for an id already in voted_mask, or for an out-of-range id. Voting is unaffected.
- Undefined: no dup_err port; such votes are silently dropped.

Test Plan:
- Reset, no cfg, start, votes ids 0,1,2 = yes, ids 3,4,5 = no -> tally = 3, result = 1, result_valid pulse 2 cycles after the id-5 accept, timed_out = 0.
- cfg_doubles = 6'b000011 with start in the same cycle, votes id0 = yes, id1 = no, others no -> tally = 2, result = 0; then a session with id0 = yes, id1 = yes -> tally = 4, result = 1.
- Start, vote id2 = yes twice (second vote_value = 0), then remaining voters no -> tally = 1, voted_mask bit2 set once; dup_err = 1 when VOTE_DUP_ERR_EN is defined.
- Start, only id0 and id1 vote yes with all weights 2 -> no further votes; TALLY at COLLECT cycle 16, tally = 4, result = 1, timed_out = 1.
- Mid-COLLECT: assert cfg_we = 6'b111111 and start -> both ignored, weights unchanged; assert reset -> busy = 0, tally = 0, result = 0, no result_valid.
- Vote id = 6 and id = 7 with vote_valid -> voted_mask and tally unchanged; vote_ready stays 1.
